// File: rtl/universal_shift_reg.sv
// Universal shift register: DEPTH stages of WIDTH-bit words with hold, shift right,
// shift left and parallel load, plus a saturating count of valid words held.
module universal_shift_reg #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       clr,
   input  logic [1:0]                 mode,
   input  logic [WIDTH-1:0]           sin_r,
   input  logic [WIDTH-1:0]           sin_l,
   input  logic [WIDTH*DEPTH-1:0]     pin,
   output logic [WIDTH*DEPTH-1:0]     pout,
   output logic [WIDTH-1:0]           sout_r,
   output logic [WIDTH-1:0]           sout_l,
   output logic [$clog2(DEPTH+1)-1:0] fill_cnt,
   output logic                       full
);

   localparam int unsigned     CntW   = $clog2(DEPTH + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(DEPTH);

   typedef enum logic [1:0] {
      ModeHold = 2'b00,
      ModeShr  = 2'b01,
      ModeShl  = 2'b10,
      ModeLoad = 2'b11
   } mode_e;

   // Packed so that stage i sits at bits [i*WIDTH +: WIDTH], matching pin/pout.
   logic [DEPTH-1:0][WIDTH-1:0] r_stage;
   logic [DEPTH-1:0][WIDTH-1:0] w_stage_d;
   logic [CntW-1:0]             r_cnt;
   logic [CntW-1:0]             w_cnt_d;
   logic [CntW-1:0]             w_cnt_sat;
   logic                        r_full;
   logic                        w_full_d;
   mode_e                       w_mode;

   assign w_mode    = mode_e'(mode);
   // Count never wraps: it sticks at DEPTH once a full frame has been seen.
   assign w_cnt_sat = (r_cnt == CntMax) ? r_cnt : r_cnt + 1'b1;

   // Next-state selection: clear beats enable, enable gates the mode decode.
   always_comb begin
      w_stage_d = r_stage;
      w_cnt_d   = r_cnt;
      if (clr) begin
         w_stage_d = '0;
         w_cnt_d   = '0;
      end else if (en) begin
         unique case (w_mode)
            ModeHold: begin
            end
            ModeShr: begin
               for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                  w_stage_d[i] = r_stage[i+1];
               end
               w_stage_d[DEPTH-1] = sin_r;
               w_cnt_d            = w_cnt_sat;
            end
            ModeShl: begin
               for (int i = 1; i < int'(DEPTH); i++) begin
                  w_stage_d[i] = r_stage[i-1];
               end
               w_stage_d[0] = sin_l;
               w_cnt_d      = w_cnt_sat;
            end
            ModeLoad: begin
               w_stage_d = pin;
               w_cnt_d   = CntMax;
            end
         endcase
      end
      // Registered flag so full needs no compare after the flop.
      w_full_d = (w_cnt_d == CntMax);
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stage <= '0;
         r_cnt   <= '0;
         r_full  <= 1'b0;
      end else begin
         r_stage <= w_stage_d;
         r_cnt   <= w_cnt_d;
         r_full  <= w_full_d;
      end
   end

   assign pout     = r_stage;
   assign sout_r   = r_stage[0];
   assign sout_l   = r_stage[DEPTH-1];
   assign fill_cnt = r_cnt;
   assign full     = r_full;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: three instances (W1/D8, W4/D4, W8/D1) driven with
// directed vectors; expectations go into a scoreboard queue tagged with the cycle
// they become due, and a separate monitor compares them against the outputs.
module tb_universal_shift_reg;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   // Instance A: WIDTH=1, DEPTH=8
   logic       a_en, a_clr;
   logic [1:0] a_mode;
   logic       a_sin_r, a_sin_l;
   logic [7:0] a_pin, a_pout;
   logic       a_sr, a_sl, a_full;
   logic [3:0] a_cnt;

   // Instance B: WIDTH=4, DEPTH=4
   logic        b_en, b_clr;
   logic [1:0]  b_mode;
   logic [3:0]  b_sin_r, b_sin_l;
   logic [15:0] b_pin, b_pout;
   logic [3:0]  b_sr, b_sl;
   logic        b_full;
   logic [2:0]  b_cnt;

   // Instance C: WIDTH=8, DEPTH=1
   logic       c_en, c_clr;
   logic [1:0] c_mode;
   logic [7:0] c_sin_r, c_sin_l;
   logic [7:0] c_pin, c_pout;
   logic [7:0] c_sr, c_sl;
   logic       c_full;
   logic [0:0] c_cnt;

   universal_shift_reg #(.WIDTH(1), .DEPTH(8)) u_a (
      .clk(clk), .rst(rst), .en(a_en), .clr(a_clr), .mode(a_mode),
      .sin_r(a_sin_r), .sin_l(a_sin_l), .pin(a_pin), .pout(a_pout),
      .sout_r(a_sr), .sout_l(a_sl), .fill_cnt(a_cnt), .full(a_full)
   );

   universal_shift_reg #(.WIDTH(4), .DEPTH(4)) u_b (
      .clk(clk), .rst(rst), .en(b_en), .clr(b_clr), .mode(b_mode),
      .sin_r(b_sin_r), .sin_l(b_sin_l), .pin(b_pin), .pout(b_pout),
      .sout_r(b_sr), .sout_l(b_sl), .fill_cnt(b_cnt), .full(b_full)
   );

   universal_shift_reg #(.WIDTH(8), .DEPTH(1)) u_c (
      .clk(clk), .rst(rst), .en(c_en), .clr(c_clr), .mode(c_mode),
      .sin_r(c_sin_r), .sin_l(c_sin_l), .pin(c_pin), .pout(c_pout),
      .sout_r(c_sr), .sout_l(c_sl), .fill_cnt(c_cnt), .full(c_full)
   );

   typedef struct {
      int          dut;
      string       name;
      logic [15:0] pout;
      logic [7:0]  sr;
      logic [7:0]  sl;
      logic [3:0]  cnt;
      logic        full;
      int          due;
   } exp_t;

   exp_t sb_q[$];
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   event e_sample;

   task automatic push(input int dut, input string nm, input logic [15:0] p,
                       input logic [7:0] sr, input logic [7:0] sl, input logic [3:0] cnt,
                       input logic full, input int delay);
      exp_t e;
      e.dut  = dut;
      e.name = nm;
      e.pout = p;
      e.sr   = sr;
      e.sl   = sl;
      e.cnt  = cnt;
      e.full = full;
      e.due  = cyc + delay;
      sb_q.push_back(e);
   endtask

   // Count edges and raise a sample point 1 time unit after every rising edge.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         -> e_sample;
      end
   end

   // Monitor: compare every scoreboard entry that has come due.
   initial begin
      forever begin
         @(e_sample);
         for (int i = 0; i < sb_q.size(); ) begin
            if (sb_q[i].due <= cyc) begin
               exp_t        e;
               logic [15:0] ap;
               logic [7:0]  asr, asl;
               logic [3:0]  acnt;
               logic        af;
               e = sb_q[i];
               sb_q.delete(i);
               case (e.dut)
                  0: begin
                     ap = {8'h00, a_pout}; asr = {7'h0, a_sr}; asl = {7'h0, a_sl};
                     acnt = a_cnt; af = a_full;
                  end
                  1: begin
                     ap = b_pout; asr = {4'h0, b_sr}; asl = {4'h0, b_sl};
                     acnt = {1'b0, b_cnt}; af = b_full;
                  end
                  default: begin
                     ap = {8'h00, c_pout}; asr = c_sr; asl = c_sl;
                     acnt = {3'b000, c_cnt}; af = c_full;
                  end
               endcase
               n_cmp++;
               if (ap !== e.pout || asr !== e.sr || asl !== e.sl ||
                   acnt !== e.cnt || af !== e.full) begin
                  n_bad++;
                  $display("FAIL %s: got pout=%h sout_r=%h sout_l=%h cnt=%0d full=%b, want pout=%h sout_r=%h sout_l=%h cnt=%0d full=%b",
                           e.name, ap, asr, asl, acnt, af, e.pout, e.sr, e.sl, e.cnt, e.full);
               end
            end else begin
               i++;
            end
         end
      end
   end

   task automatic drv_a(input bit en, input bit clr, input bit [1:0] mode,
                        input bit sr, input bit sl, input bit [7:0] pin);
      a_en = en; a_clr = clr; a_mode = mode; a_sin_r = sr; a_sin_l = sl; a_pin = pin;
   endtask

   task automatic drv_b(input bit en, input bit clr, input bit [1:0] mode,
                        input bit [3:0] sr, input bit [3:0] sl, input bit [15:0] pin);
      b_en = en; b_clr = clr; b_mode = mode; b_sin_r = sr; b_sin_l = sl; b_pin = pin;
   endtask

   task automatic drv_c(input bit en, input bit clr, input bit [1:0] mode,
                        input bit [7:0] sr, input bit [7:0] sl, input bit [7:0] pin);
      c_en = en; c_clr = clr; c_mode = mode; c_sin_r = sr; c_sin_l = sl; c_pin = pin;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // SISO vector for instance A and the pout expected after each edge.
   bit         a_sin_tab [15] = '{1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
   logic [7:0] a_pout_tab[15] = '{8'h80, 8'hC0, 8'hE0, 8'h70, 8'h38, 8'h9C, 8'hCE, 8'h67,
                                  8'h33, 8'h19, 8'h0C, 8'h06, 8'h03, 8'h01, 8'h00};

   // Instance B shift-left words and expected pout / sout_r / sout_l / count.
   logic [3:0]  b_shl_in [5] = '{4'h9, 4'h0, 4'hE, 4'h7, 4'h5};
   logic [15:0] b_shl_p  [5] = '{16'h0009, 16'h0090, 16'h090E, 16'h90E7, 16'h0E75};
   logic [3:0]  b_shl_sr [5] = '{4'h9, 4'h0, 4'hE, 4'h7, 4'h5};
   logic [3:0]  b_shl_sl [5] = '{4'h0, 4'h0, 4'h0, 4'h9, 4'h0};
   logic [3:0]  b_shl_cnt[5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4};

   // Instance B PISO: sout_r after each right shift of a loaded A5C3.
   logic [15:0] b_piso_p [4] = '{16'h0A5C, 16'h00A5, 16'h000A, 16'h0000};
   logic [3:0]  b_piso_sr[4] = '{4'hC, 4'h5, 4'hA, 4'h0};

   initial begin
      drv_a(0, 0, 2'b00, 0, 0, 8'h00);
      drv_b(0, 0, 2'b00, 4'h0, 4'h0, 16'h0000);
      drv_c(0, 0, 2'b00, 8'h00, 8'h00, 8'h00);

      // Reset state of every instance.
      #2 rst = 1'b0;
      #1;
      push(0, "reset_a", 16'h0, 8'h0, 8'h0, 4'd0, 1'b0, 0);
      push(1, "reset_b", 16'h0, 8'h0, 8'h0, 4'd0, 1'b0, 0);
      push(2, "reset_c", 16'h0, 8'h0, 8'h0, 4'd0, 1'b0, 0);
      -> e_sample;
      tick();
      tick();
      rst = 1'b1;
      push(0, "idle_after_reset_a", 16'h0, 8'h0, 8'h0, 4'd0, 1'b0, 1);
      tick();

      // SISO on A: sout_r reproduces the input DEPTH edges later.
      for (int k = 0; k < 15; k++) begin
         logic [7:0] p;
         int         c;
         p = a_pout_tab[k];
         c = (k + 1 > 8) ? 8 : k + 1;
         drv_a(1, 0, 2'b01, a_sin_tab[k], ~a_sin_tab[k], 8'hFF);
         push(0, $sformatf("siso_a_%0d", k + 1), {8'h00, p}, {7'h0, p[0]}, {7'h0, p[7]},
              4'(c), (c == 8), 1);
         tick();
      end

      // Load non-zero content, then assert reset between edges.
      drv_a(1, 0, 2'b11, 0, 0, 8'h5A);
      push(0, "load_a", 16'h005A, 8'h0, 8'h0, 4'd8, 1'b1, 1);
      tick();
      drv_a(0, 0, 2'b00, 0, 0, 8'h00);
      #2 rst = 1'b0;
      #1;
      push(0, "async_reset_a", 16'h0, 8'h0, 8'h0, 4'd0, 1'b0, 0);
      -> e_sample;
      drv_a(1, 0, 2'b01, 1, 1, 8'h00);
      push(0, "reset_held_a", 16'h0, 8'h0, 8'h0, 4'd0, 1'b0, 1);
      tick();
      rst = 1'b1;
      drv_a(0, 0, 2'b01, 1, 1, 8'h00);
      push(0, "release_en0_a", 16'h0, 8'h0, 8'h0, 4'd0, 1'b0, 1);
      tick();
      drv_a(1, 0, 2'b01, 1, 0, 8'h00);
      push(0, "first_shift_a", 16'h0080, 8'h0, 8'h1, 4'd1, 1'b0, 1);
      tick();
      drv_a(0, 0, 2'b00, 0, 0, 8'h00);

      // PISO on B.
      drv_b(1, 0, 2'b11, 4'h0, 4'hF, 16'hA5C3);
      push(1, "piso_load_b", 16'hA5C3, 8'h3, 8'hA, 4'd4, 1'b1, 1);
      tick();
      for (int k = 0; k < 4; k++) begin
         drv_b(1, 0, 2'b01, 4'h0, 4'hF, 16'hFFFF);
         push(1, $sformatf("piso_b_%0d", k + 1), b_piso_p[k], {4'h0, b_piso_sr[k]}, 8'h0,
              4'd4, 1'b1, 1);
         tick();
      end

      // Clear, then shift left on B; count saturates at 4.
      drv_b(1, 1, 2'b01, 4'hF, 4'hF, 16'hFFFF);
      push(1, "clr_b", 16'h0, 8'h0, 8'h0, 4'd0, 1'b0, 1);
      tick();
      for (int k = 0; k < 5; k++) begin
         drv_b(1, 0, 2'b10, 4'hF, b_shl_in[k], 16'hFFFF);
         push(1, $sformatf("shl_b_%0d", k + 1), b_shl_p[k], {4'h0, b_shl_sr[k]},
              {4'h0, b_shl_sl[k]}, b_shl_cnt[k], (b_shl_cnt[k] == 4'd4), 1);
         tick();
      end

      // Enable low freezes B; clear beats enable-low and load.
      for (int k = 0; k < 3; k++) begin
         drv_b(0, 0, 2'b01, 4'hF, 4'hF, 16'hFFFF);
         push(1, $sformatf("en0_hold_b_%0d", k + 1), 16'h0E75, 8'h5, 8'h0, 4'd4, 1'b1, 1);
         tick();
      end
      drv_b(0, 1, 2'b11, 4'hF, 4'hF, 16'hFFFF);
      push(1, "clr_en0_load_b", 16'h0, 8'h0, 8'h0, 4'd0, 1'b0, 1);
      tick();
      drv_b(0, 0, 2'b11, 4'hF, 4'hF, 16'hFFFF);
      push(1, "en0_blocks_load_b", 16'h0, 8'h0, 8'h0, 4'd0, 1'b0, 1);
      tick();
      drv_b(1, 0, 2'b00, 4'hF, 4'hF, 16'hFFFF);
      push(1, "mode_hold_b", 16'h0, 8'h0, 8'h0, 4'd0, 1'b0, 1);
      tick();
      drv_b(1, 0, 2'b01, 4'h6, 4'hF, 16'hFFFF);
      push(1, "shr_from_clr_b", 16'h6000, 8'h0, 8'h6, 4'd1, 1'b0, 1);
      tick();
      drv_b(1, 0, 2'b11, 4'hF, 4'hF, 16'h1234);
      push(1, "reload_b", 16'h1234, 8'h4, 8'h1, 4'd4, 1'b1, 1);
      tick();
      drv_b(0, 0, 2'b00, 4'h0, 4'h0, 16'h0000);

      // DEPTH=1 on C: each shift replaces the single stage, count saturates at 1.
      drv_c(1, 0, 2'b01, 8'h11, 8'hEE, 8'hEE);
      push(2, "d1_shr_11", 16'h0011, 8'h11, 8'h11, 4'd1, 1'b1, 1);
      tick();
      drv_c(1, 0, 2'b01, 8'h22, 8'hEE, 8'hEE);
      push(2, "d1_shr_22", 16'h0022, 8'h22, 8'h22, 4'd1, 1'b1, 1);
      tick();
      drv_c(1, 0, 2'b01, 8'h33, 8'hEE, 8'hEE);
      push(2, "d1_shr_33", 16'h0033, 8'h33, 8'h33, 4'd1, 1'b1, 1);
      tick();
      drv_c(1, 0, 2'b10, 8'hEE, 8'h44, 8'hEE);
      push(2, "d1_shl_44", 16'h0044, 8'h44, 8'h44, 4'd1, 1'b1, 1);
      tick();
      drv_c(1, 0, 2'b10, 8'hEE, 8'h55, 8'hEE);
      push(2, "d1_shl_55", 16'h0055, 8'h55, 8'h55, 4'd1, 1'b1, 1);
      tick();
      drv_c(1, 1, 2'b11, 8'hEE, 8'hEE, 8'hEE);
      push(2, "d1_clr", 16'h0, 8'h0, 8'h0, 4'd0, 1'b0, 1);
      tick();
      drv_c(0, 0, 2'b01, 8'hEE, 8'hEE, 8'hEE);
      push(2, "d1_en0", 16'h0, 8'h0, 8'h0, 4'd0, 1'b0, 1);
      tick();
      drv_c(1, 0, 2'b11, 8'hEE, 8'hEE, 8'hA7);
      push(2, "d1_load", 16'h00A7, 8'hA7, 8'hA7, 4'd1, 1'b1, 1);
      tick();
      drv_c(1, 0, 2'b00, 8'hEE, 8'hEE, 8'h00);
      push(2, "d1_hold", 16'h00A7, 8'hA7, 8'hA7, 4'd1, 1'b1, 1);
      tick();
      drv_c(0, 0, 2'b00, 8'h00, 8'h00, 8'h00);

      // Every pushed expectation must have been consumed by the monitor.
      tick();
      tick();
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout at cycle %0d, want completion", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
